x9_prog_counter: RTL

- Program counter and branch-resolution stage for the X9 core; it is the instruction-fetch address source.
- It consumes the ALU's `one` flag, which is the branch-taken condition, together with decoder branch strobes.
- It produces the next instruction address each cycle.
- It resolves absolute branches through an internal, software-loadable branch-target LUT, and relative branches through a signed 8-bit offset.
- It sequences start, run and done for a program.

---
 rtl/x9_prog_counter_if.sv | 45 ++++
 rtl/x9_prog_counter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/x9_prog_counter_if.sv
// x9_prog_counter_if: control strobes, branch operands, LUT write port and
// status for the X9 program counter. The decoder/sequencer drives through the
// master modport; the PC stage receives through the slave modport.
interface x9_prog_counter_if #(
   parameter int PW     = 10,
   parameter int LUT_AW = 5
);
   // program sequencing
   logic              start;
   logic              stall;
   logic              halt_i;
   // branch resolution
   logic              br_abs;
   logic              br_rel;
   logic              one_i;
   logic [LUT_AW-1:0] lut_idx;
   logic [7:0]        rel_off;
   // branch-target LUT write port
   logic              lut_we;
   logic [LUT_AW-1:0] lut_waddr;
   logic [PW-1:0]     lut_wdata;
   // call / return (only acted on when the link feature is built)
   logic              call_i;
   logic              ret_i;
   // status
   logic [PW-1:0]     prog_cnt;
   logic              busy;
   logic              done;

   modport master (
      output start, stall, halt_i,
      output br_abs, br_rel, one_i, lut_idx, rel_off,
      output lut_we, lut_waddr, lut_wdata,
      output call_i, ret_i,
      input  prog_cnt, busy, done
   );

   modport slave (
      input  start, stall, halt_i,
      input  br_abs, br_rel, one_i, lut_idx, rel_off,
      input  lut_we, lut_waddr, lut_wdata,
      input  call_i, ret_i,
      output prog_cnt, busy, done
   );
endinterface

// File: rtl/x9_prog_counter.sv
// x9_prog_counter: instruction-fetch address source and branch resolution for
// the X9 core. IDLE/RUN/DONE sequencer, absolute branches through a
// software-loadable target LUT, relative branches through a signed 8-bit
// offset, all PC arithmetic modulo 2^PW.
// Optional feature macro: X9_CALL_LINK_EN builds a one-entry link register
// for call/return. Without it, call_i/ret_i are ignored.
// PW must be greater than 8 (the relative offset is sign-extended into PW).
module x9_prog_counter #(
   parameter int PW         = 10,
   parameter int LUT_AW     = 5,
   parameter int START_ADDR = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   x9_prog_counter_if.slave      pc_if
);

   localparam int            LUT_DEPTH = 2 ** LUT_AW;
   localparam logic [PW-1:0] START_PC  = PW'(START_ADDR);
   localparam logic [PW-1:0] PC_ONE    = PW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pc_q, pc_d;
   logic          busy_q, done_q;

   logic [PW-1:0] lut_q [LUT_DEPTH];
   logic [PW-1:0] lut_rd;
   logic [PW-1:0] rel_ext;
   logic [PW-1:0] pc_inc;
   logic          abs_taken;
   logic          rel_taken;

   // ------------------------------------------------------------------
   // Branch-target LUT: one register per entry, synchronous write in any
   // state (stall does not block software loading). The read is a plain
   // mux off the registers, so a same-cycle write to the entry being read
   // still returns the old contents.
   // ------------------------------------------------------------------
   for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
      // entry g: cleared on reset, loaded when addressed by the write port
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            lut_q[g] <= '0;
         end else if (pc_if.lut_we && (pc_if.lut_waddr == LUT_AW'(g))) begin
            lut_q[g] <= pc_if.lut_wdata;
         end
      end
   end

   assign lut_rd = lut_q[pc_if.lut_idx];

   // ------------------------------------------------------------------
   // Datapath helpers. Additions are PW bits wide and simply drop the
   // carry, which gives the modulo-2^PW wrap in both directions.
   // ------------------------------------------------------------------
   assign rel_ext   = {{(PW-8){pc_if.rel_off[7]}}, pc_if.rel_off};
   assign pc_inc    = pc_q + PC_ONE;
   assign abs_taken = pc_if.br_abs & pc_if.one_i;
   assign rel_taken = pc_if.br_rel & pc_if.one_i;

`ifdef X9_CALL_LINK_EN
   logic [PW-1:0] link_q, link_d;

   // link register: return address captured on call, held otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         link_q <= '0;
      end else begin
         link_q <= link_d;
      end
   end
`else
   // call/ret are accepted on the interface but have no effect in this build
   logic unused_call_ret;
   assign unused_call_ret = &{1'b0, pc_if.call_i, pc_if.ret_i};
`endif

   // ------------------------------------------------------------------
   // Sequencer / PC next-state. Strobes only matter in RUN; start only
   // matters in IDLE and DONE. In RUN the priority is
   // stall > halt > (call > ret) > br_abs > br_rel > increment.
   // ------------------------------------------------------------------
   // next state, next PC and next link from current state and strobes
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
`ifdef X9_CALL_LINK_EN
      link_d  = link_q;
`endif
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (pc_if.start) begin
               pc_d    = START_PC;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (pc_if.stall) begin
               // hold everything
            end else if (pc_if.halt_i) begin
               // PC keeps the address of the halt instruction
               state_d = ST_DONE;
            end
`ifdef X9_CALL_LINK_EN
            else if (pc_if.call_i) begin
               // calls are unconditional; a nested call overwrites the link
               link_d = pc_inc;
               pc_d   = lut_rd;
            end else if (pc_if.ret_i) begin
               pc_d = link_q;
            end
`endif
            else if (abs_taken) begin
               pc_d = lut_rd;
            end else if (rel_taken) begin
               pc_d = pc_q + rel_ext;
            end else begin
               pc_d = pc_inc;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state and PC registers; reset aborts a running program at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // status flags registered from the next state so they align with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= (state_d == ST_RUN);
         done_q <= (state_d == ST_DONE);
      end
   end

   assign pc_if.prog_cnt = pc_q;
   assign pc_if.busy     = busy_q;
   assign pc_if.done     = done_q;

endmodule
